// File: rtl/crono_pkg.sv
// Shared types and constants for the chronometer countdown: FSM states,
// H:M:S field widths and the saturation / field-wise decrement helpers.
package crono_pkg;

  localparam int HORA_W = 4;
  localparam int MS_W   = 6;
  localparam logic [MS_W-1:0] MAX_MS = MS_W'(59);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_e;

  typedef struct packed {
    logic [HORA_W-1:0] hora;
    logic [MS_W-1:0]   min;
    logic [MS_W-1:0]   seg;
  } hms_t;

  function automatic logic [MS_W-1:0] sat_ms(input logic [MS_W-1:0] v);
    return (v > MAX_MS) ? MAX_MS : v;
  endfunction

  // Borrow ripples seg -> min -> hora; a field at zero is never decremented.
  function automatic hms_t hms_dec(input hms_t t);
    hms_t r;
    r = t;
    if (t.seg != '0) begin
      r.seg = t.seg - MS_W'(1);
    end else if (t.min != '0) begin
      r.min = t.min - MS_W'(1);
      r.seg = MAX_MS;
    end else if (t.hora != '0) begin
      r.hora = t.hora - HORA_W'(1);
      r.min  = MAX_MS;
      r.seg  = MAX_MS;
    end
    return r;
  endfunction

endpackage

// File: rtl/crono_countdown_if.sv
// Bus between the setpoint/control side (master) and the countdown engine (slave).
interface crono_countdown_if;
  import crono_pkg::*;

  logic [HORA_W-1:0] crono_hora;
  logic [MS_W-1:0]   crono_min;
  logic [MS_W-1:0]   crono_seg;
  logic              start;
  logic              pausa;
  logic              cancel;
  logic              ack;
  logic [HORA_W-1:0] rest_hora;
  logic [MS_W-1:0]   rest_min;
  logic [MS_W-1:0]   rest_seg;
  logic              corriendo;
  logic              fin;
  logic              tick;

  modport master (
    output crono_hora, crono_min, crono_seg, start, pausa, cancel, ack,
    input  rest_hora, rest_min, rest_seg, corriendo, fin, tick
  );

  modport slave (
    input  crono_hora, crono_min, crono_seg, start, pausa, cancel, ack,
    output rest_hora, rest_min, rest_seg, corriendo, fin, tick
  );
endinterface

// File: rtl/crono_prescaler.sv
// Seconds prescaler: counts 0..TICK_CYCLES-1 while enabled, strobes at terminal count.
module crono_prescaler #(
  parameter int unsigned TICK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TC_LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == TC_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/crono_countdown.sv
// Countdown engine: loads the saturated H:M:S setpoint, counts it down at 1 Hz,
// raises fin on expiry and auto-returns to IDLE after ALARM_SEC seconds.
module crono_countdown
  import crono_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100_000_000,
  parameter int unsigned ALARM_SEC   = 10
) (
  input  logic               clk,
  input  logic               rst,
  crono_countdown_if.slave   bus
);
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

  state_e        state_q;
  hms_t          rest_q;
  logic          corriendo_q;
  logic          fin_q;
  logic [AW-1:0] alarm_q;

  hms_t setp, dec;
  logic presc_en, presc_clr, presc_tick;
  logic do_cancel, do_ack, do_pausa, do_start;

  assign setp = '{hora: bus.crono_hora,
                  min:  sat_ms(bus.crono_min),
                  seg:  sat_ms(bus.crono_seg)};
  assign dec  = hms_dec(rest_q);

  // Only the highest-priority pulse of a cycle is acted upon.
  assign do_cancel = bus.cancel;
  assign do_ack    = !bus.cancel && bus.ack;
  assign do_pausa  = !bus.cancel && !bus.ack && bus.pausa;
  assign do_start  = !bus.cancel && !bus.ack && !bus.pausa && bus.start;

  assign presc_en  = (state_q == S_RUN) || (state_q == S_ALARM);
  assign presc_clr = (state_q == S_IDLE);

  crono_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .en_i   (presc_en),
    .clr_i  (presc_clr),
    .tick_o (presc_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rest_q      <= '0;
      corriendo_q <= 1'b0;
      fin_q       <= 1'b0;
      alarm_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rest_q <= setp;
          if (do_start && setp != '0) begin
            state_q     <= S_RUN;
            corriendo_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (do_cancel) begin
            state_q     <= S_IDLE;
            corriendo_q <= 1'b0;
          end else if (presc_tick && dec == '0) begin
            rest_q      <= dec;
            state_q     <= S_ALARM;
            corriendo_q <= 1'b0;
            fin_q       <= 1'b1;
            alarm_q     <= '0;
          end else begin
            if (presc_tick) rest_q <= dec;
            if (do_pausa) begin
              state_q     <= S_PAUSE;
              corriendo_q <= 1'b0;
            end
          end
        end
        S_PAUSE: begin
          if (do_cancel) begin
            state_q <= S_IDLE;
          end else if (do_start) begin
            state_q     <= S_RUN;
            corriendo_q <= 1'b1;
          end
        end
        S_ALARM: begin
          if (do_cancel || do_ack || (presc_tick && alarm_q == ALARM_LAST)) begin
            state_q <= S_IDLE;
            fin_q   <= 1'b0;
          end else if (presc_tick) begin
            alarm_q <= alarm_q + AW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rest_hora = rest_q.hora;
  assign bus.rest_min  = rest_q.min;
  assign bus.rest_seg  = rest_q.seg;
  assign bus.corriendo = corriendo_q;
  assign bus.fin       = fin_q;
  assign bus.tick      = (state_q == S_RUN) && presc_tick;
endmodule

// File: tb/tb_crono_countdown.sv
// Self-checking bench for crono_countdown: directed scenarios plus random pulses,
// compared each cycle against a flat-seconds reference model.
module tb_crono_countdown;
  localparam int TC = 4;
  localparam int AS = 3;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_ALARM} mmode_e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crono_countdown_if bus ();

  crono_countdown #(.TICK_CYCLES(TC), .ALARM_SEC(AS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  mmode_e m_mode;
  int     m_presc;
  int     m_rem;
  int     m_alarm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  function automatic int setpoint_secs();
    return int'(bus.crono_hora) * 3600 + sat(int'(bus.crono_min)) * 60 + sat(int'(bus.crono_seg));
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_presc = 0;
    m_rem   = 0;
    m_alarm = 0;
  endtask

  // Reference behaviour for one clock edge, given the pulses seen before the edge.
  task automatic model_edge(input bit st, input bit pa, input bit ca, input bit ak);
    mmode_e old_mode = m_mode;
    bit     wrap     = (m_presc == TC - 1) && (m_mode == M_RUN || m_mode == M_ALARM);
    bit     w_ca     = ca;
    bit     w_ak     = !ca && ak;
    bit     w_pa     = !ca && !ak && pa;
    bit     w_st     = !ca && !ak && !pa && st;
    int     sp       = setpoint_secs();
    case (m_mode)
      M_IDLE: begin
        m_rem = sp;
        if (w_st && sp != 0) m_mode = M_RUN;
      end
      M_RUN: begin
        if (w_ca) m_mode = M_IDLE;
        else begin
          if (wrap) m_rem = m_rem - 1;
          if (wrap && m_rem == 0) begin
            m_mode  = M_ALARM;
            m_alarm = 0;
          end else if (w_pa) m_mode = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (w_ca) m_mode = M_IDLE;
        else if (w_st) m_mode = M_RUN;
      end
      M_ALARM: begin
        if (w_ca || w_ak) m_mode = M_IDLE;
        else if (wrap) begin
          m_alarm = m_alarm + 1;
          if (m_alarm == AS) m_mode = M_IDLE;
        end
      end
      default: m_mode = M_IDLE;
    endcase
    if (old_mode == M_IDLE)                           m_presc = 0;
    else if (old_mode == M_RUN || old_mode == M_ALARM) m_presc = wrap ? 0 : m_presc + 1;
  endtask

  task automatic compare_all();
    check("rest_hora", bus.rest_hora, m_rem / 3600);
    check("rest_min",  bus.rest_min,  (m_rem % 3600) / 60);
    check("rest_seg",  bus.rest_seg,  m_rem % 60);
    check("corriendo", bus.corriendo, m_mode == M_RUN);
    check("fin",       bus.fin,       m_mode == M_ALARM);
    check("tick",      bus.tick,      (m_mode == M_RUN) && (m_presc == TC - 1));
  endtask

  // One clock cycle: drive pulses, update model on the edge, compare on the falling edge.
  task automatic cyc(input bit st, input bit pa, input bit ca, input bit ak);
    bus.start  = st;
    bus.pausa  = pa;
    bus.cancel = ca;
    bus.ack    = ak;
    @(posedge clk);
    model_edge(st, pa, ca, ak);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.pausa  = 1'b0;
    bus.cancel = 1'b0;
    bus.ack    = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_sp(input int h, input int m, input int s);
    bus.crono_hora = 4'(h);
    bus.crono_min  = 6'(m);
    bus.crono_seg  = 6'(s);
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.pausa = 1'b0; bus.cancel = 1'b0; bus.ack = 1'b0;
    set_sp(0, 0, 2);
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b1;
    idle(2);

    // 1: two-second countdown, then alarm auto-return after AS seconds
    cyc(1, 0, 0, 0);
    idle(3);
    check("t1_tick1", bus.tick, 1);
    idle(1);
    check("t1_seg1", bus.rest_seg, 1);
    idle(3);
    check("t1_tick2", bus.tick, 1);
    idle(1);
    check("t1_fin", bus.fin, 1);
    check("t1_seg0", bus.rest_seg, 0);
    check("t1_run0", bus.corriendo, 0);
    idle(11);
    check("t5_fin_hold", bus.fin, 1);
    idle(1);
    check("t5_fin_auto", bus.fin, 0);

    // 2: borrow across fields; setpoint changes ignored while running
    set_sp(1, 0, 0);
    idle(1);
    cyc(1, 0, 0, 0);
    idle(4);
    check("t2_hora", bus.rest_hora, 0);
    check("t2_min",  bus.rest_min, 59);
    check("t2_seg",  bus.rest_seg, 59);
    cyc(0, 0, 1, 0);
    set_sp(0, 1, 0);
    idle(1);
    cyc(1, 0, 0, 0);
    set_sp(0, 30, 30);
    idle(4);
    check("t2b_min", bus.rest_min, 0);
    check("t2b_seg", bus.rest_seg, 59);
    cyc(0, 0, 1, 0);

    // 3: pause freezes time and prescaler; resume keeps the prescaler phase
    set_sp(0, 0, 5);
    idle(1);
    cyc(1, 0, 0, 0);
    idle(1);
    cyc(0, 1, 0, 0);
    idle(20);
    check("t3_frozen", bus.rest_seg, 5);
    check("t3_run0", bus.corriendo, 0);
    cyc(1, 0, 0, 0);
    check("t3_notick", bus.tick, 0);
    idle(1);
    check("t3_tick", bus.tick, 1);
    cyc(0, 0, 1, 0);

    // 4: zero setpoint ignored; saturation in IDLE
    set_sp(0, 0, 0);
    idle(1);
    cyc(1, 0, 0, 0);
    idle(2);
    check("t4_run0", bus.corriendo, 0);
    check("t4_fin0", bus.fin, 0);
    set_sp(0, 63, 62);
    idle(1);
    check("t4_satmin", bus.rest_min, 59);
    check("t4_satseg", bus.rest_seg, 59);

    // 5: ack silences alarm; cancel beats start in RUN
    set_sp(0, 0, 1);
    idle(1);
    cyc(1, 0, 0, 0);
    idle(4);
    check("t5_alarm", bus.fin, 1);
    cyc(0, 0, 0, 1);
    check("t5_ack", bus.fin, 0);
    set_sp(0, 0, 3);
    idle(1);
    cyc(1, 0, 0, 0);
    idle(1);
    cyc(1, 0, 1, 0);
    check("t5_cancel", bus.corriendo, 0);
    idle(1);

    // 6: asynchronous reset between edges mid-RUN
    set_sp(0, 0, 9);
    idle(1);
    cyc(1, 0, 0, 0);
    idle(5);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("t6_seg",  bus.rest_seg, 0);
    check("t6_run",  bus.corriendo, 0);
    check("t6_fin",  bus.fin, 0);
    check("t6_tick", bus.tick, 0);
    @(negedge clk);
    compare_all();
    rst = 1'b1;
    idle(1);
    check("t6_load", bus.rest_seg, 9);

    // Random pulses and setpoints against the reference model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        set_sp(($urandom_range(0, 15) == 0) ? 1 : 0,
               ($urandom_range(0, 7) == 0) ? $urandom_range(58, 63) : $urandom_range(0, 1),
               ($urandom_range(0, 7) == 0) ? $urandom_range(58, 63) : $urandom_range(0, 4));
      end
      cyc($urandom_range(0, 99) < 10, $urandom_range(0, 24) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
